// File: rtl/ifft4.sv
// ifft4: four-point radix-2 inverse FFT, two time-multiplexed butterfly stages,
// optional 1/4 scaling, start/done handshake.
module ifft4 #(
    parameter int WIDTH = 32,
    parameter bit SCALE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3
);
    localparam int H = WIDTH / 2;
    localparam int I = H + 2;

    typedef enum logic [1:0] {IDLE, S1, S2} state_t;

    state_t              r_state, w_next;
    logic [WIDTH-1:0]    r_x   [4];
    logic [WIDTH-1:0]    r_out [4];
    logic signed [I-1:0] w_xr  [4];
    logic signed [I-1:0] w_xi  [4];
    logic signed [I-1:0] r_er  [2];
    logic signed [I-1:0] r_ei  [2];
    logic signed [I-1:0] r_or  [2];
    logic signed [I-1:0] r_oi  [2];
    logic signed [I-1:0] w_yr  [4];
    logic signed [I-1:0] w_yi  [4];
    logic                r_done;

    function automatic logic [H-1:0] fit(input logic signed [I-1:0] y);
        return SCALE ? y[I-1:2] : y[H-1:0];
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_ext
        assign w_xr[k] = I'($signed(r_x[k][WIDTH-1:H]));
        assign w_xi[k] = I'($signed(r_x[k][H-1:0]));
    end

    // Inverse twiddle: e1 +/- j*o1, with j*(a+jb) = -b + ja
    assign w_yr[0] = r_er[0] + r_or[0];
    assign w_yi[0] = r_ei[0] + r_oi[0];
    assign w_yr[2] = r_er[0] - r_or[0];
    assign w_yi[2] = r_ei[0] - r_oi[0];
    assign w_yr[1] = r_er[1] - r_oi[1];
    assign w_yi[1] = r_ei[1] + r_or[1];
    assign w_yr[3] = r_er[1] + r_oi[1];
    assign w_yi[3] = r_ei[1] - r_or[1];

    always_comb begin
        w_next = (r_state == IDLE) ? (start ? S1 : IDLE) : (r_state == S1) ? S2 : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_x[i]   <= '0;
                r_out[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                r_er[i] <= '0;
                r_ei[i] <= '0;
                r_or[i] <= '0;
                r_oi[i] <= '0;
            end
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S2);
            if (r_state == IDLE && start) begin
                r_x[0] <= in0;
                r_x[1] <= in1;
                r_x[2] <= in2;
                r_x[3] <= in3;
            end
            if (r_state == S1) begin
                r_er[0] <= w_xr[0] + w_xr[2];
                r_er[1] <= w_xr[0] - w_xr[2];
                r_or[0] <= w_xr[1] + w_xr[3];
                r_or[1] <= w_xr[1] - w_xr[3];
                r_ei[0] <= w_xi[0] + w_xi[2];
                r_ei[1] <= w_xi[0] - w_xi[2];
                r_oi[0] <= w_xi[1] + w_xi[3];
                r_oi[1] <= w_xi[1] - w_xi[3];
            end
            if (r_state == S2)
                for (int i = 0; i < 4; i++) r_out[i] <= {fit(w_yr[i]), fit(w_yi[i])};
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign out0 = r_out[0];
    assign out1 = r_out[1];
    assign out2 = r_out[2];
    assign out3 = r_out[3];
endmodule

// File: tb/tb_ifft4.sv
// tb_ifft4: randomized and directed checks of ifft4 (scaled and unscaled builds)
// against a direct inverse-DFT reference model.
module tb_ifft4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic        busy, done, busy_u, done_u;
    logic [31:0] out0, out1, out2, out3, uo0, uo1, uo2, uo3;
    logic [31:0] got_s [4];
    logic [31:0] got_u [4];
    logic [31:0] exp_s [4];
    logic [31:0] exp_u [4];
    int n_cmp = 0;
    int n_err = 0;

    ifft4 #(.WIDTH(32), .SCALE(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .busy(busy), .done(done),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3)
    );

    ifft4 #(.WIDTH(32), .SCALE(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .busy(busy_u), .done(done_u),
        .out0(uo0), .out1(uo1), .out2(uo2), .out3(uo3)
    );

    assign got_s[0] = out0;
    assign got_s[1] = out1;
    assign got_s[2] = out2;
    assign got_s[3] = out3;
    assign got_u[0] = uo0;
    assign got_u[1] = uo1;
    assign got_u[2] = uo2;
    assign got_u[3] = uo3;

    always #5 clk = ~clk;

    // x[n] = sum_k X[k] * j^(k*n), then floor(/4) or wrap to 16 bits
    task automatic model(input logic [31:0] a0, a1, a2, a3);
        logic [31:0] xv [4];
        int re, im, xr, xi;
        xv[0] = a0; xv[1] = a1; xv[2] = a2; xv[3] = a3;
        for (int n = 0; n < 4; n++) begin
            re = 0;
            im = 0;
            for (int k = 0; k < 4; k++) begin
                xr = int'($signed(xv[k][31:16]));
                xi = int'($signed(xv[k][15:0]));
                case ((k * n) % 4)
                    0: begin re += xr; im += xi; end
                    1: begin re -= xi; im += xr; end
                    2: begin re -= xr; im -= xi; end
                    default: begin re += xi; im -= xr; end
                endcase
            end
            exp_s[n] = {16'(re >>> 2), 16'(im >>> 2)};
            exp_u[n] = {16'(re), 16'(im)};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rc();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rw();
        return {rc(), rc()};
    endfunction

    // Drive inputs, pulse start across the accepting edge, stop just after edge N+2
    task automatic launch(input logic [31:0] a0, a1, a2, a3);
        in0 = a0; in1 = a1; in2 = a2; in3 = a3;
        model(a0, a1, a2, a3);
        start = 1'b1;
        tick();
        start = 1'b0;
        in0 = $urandom; in1 = $urandom; in2 = $urandom; in3 = $urandom;
        tick();
        tick();
    endtask

    task automatic test_reset();
        launch(32'h00040000, 32'h0, 32'h0, 32'h0);
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL reset_dc_done: got %b want 1", done); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_s[i] !== 32'h00010000) begin
                n_err++; $display("FAIL reset_dc_out%0d: got %h want 00010000", i, got_s[i]);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, busy_u, done_u} !== 4'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000", {busy, done, busy_u, done_u});
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_s[i] !== 32'h0 || got_u[i] !== 32'h0) begin
                n_err++; $display("FAIL reset_out%0d: got %h/%h want 0", i, got_s[i], got_u[i]);
            end
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] vin [4][4];
        logic [31:0] vexp [4][4];
        logic [31:0] uexp [4];
        vin[0]  = '{32'h00040000, 32'h0, 32'h0, 32'h0};
        vexp[0] = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
        vin[1]  = '{32'h0, 32'h00040000, 32'h0, 32'h0};
        vexp[1] = '{32'h00010000, 32'h00000001, 32'hFFFF0000, 32'h0000FFFF};
        vin[2]  = '{32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000};
        vexp[2] = '{32'h7FFF0000, 32'h0, 32'h0, 32'h0};
        vin[3]  = '{32'hFFFF0000, 32'h0, 32'h0, 32'h0};
        vexp[3] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000};
        for (int v = 0; v < 4; v++) begin
            launch(vin[v][0], vin[v][1], vin[v][2], vin[v][3]);
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_s[i] !== vexp[v][i]) begin
                    n_err++; $display("FAIL directed%0d_out%0d: got %h want %h", v, i, got_s[i], vexp[v][i]);
                end
            end
        end
        uexp = '{32'h00040004, 32'h0, 32'h0, 32'h0};
        launch(32'h00010001, 32'h00010001, 32'h00010001, 32'h00010001);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_u[i] !== uexp[i]) begin
                n_err++; $display("FAIL unscaled_out%0d: got %h want %h", i, got_u[i], uexp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a [4];
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 4; i++) a[i] = rw();
            in0 = a[0]; in1 = a[1]; in2 = a[2]; in3 = a[3];
            model(a[0], a[1], a[2], a[3]);
            start = 1'b1;
            tick();
            start = 1'b0;
            in0 = $urandom; in1 = $urandom; in2 = $urandom; in3 = $urandom;
            n_cmp++;
            if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL rand_s1_flags: got %b want 10", {busy, done}); end
            tick();
            n_cmp++;
            if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL rand_s2_flags: got %b want 10", {busy, done}); end
            tick();
            n_cmp++;
            if ({busy, done, done_u} !== 3'b011) begin
                n_err++; $display("FAIL rand_done_flags: got %b want 011", {busy, done, done_u});
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_s[i] !== exp_s[i] || got_u[i] !== exp_u[i]) begin
                    n_err++;
                    $display("FAIL rand_out%0d: got %h/%h want %h/%h", i, got_s[i], got_u[i], exp_s[i], exp_u[i]);
                end
            end
            tick();
            n_cmp++;
            if (done !== 1'b0 || got_s[0] !== exp_s[0]) begin
                n_err++; $display("FAIL rand_hold: got done=%b out0=%h want done=0 out0=%h", done, got_s[0], exp_s[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        in0 = rw(); in1 = rw(); in2 = rw(); in3 = rw();
        model(in0, in1, in2, in3);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_cmp++;
            if (done !== (c % 3 == 0) || (done && busy)) begin
                n_err++; $display("FAIL b2b_cycle%0d: got done=%b busy=%b want done=%b", c, done, busy, c % 3 == 0);
            end
            if (c % 3 == 0)
                for (int i = 0; i < 4; i++) begin
                    n_cmp++;
                    if (got_s[i] !== exp_s[i]) begin
                        n_err++; $display("FAIL b2b_out%0d: got %h want %h", i, got_s[i], exp_s[i]);
                    end
                end
        end
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL b2b_drain: got %b want 1", done); end
        tick();
    endtask

    task automatic test_start_in_s1();
        in0 = rw(); in1 = rw(); in2 = rw(); in3 = rw();
        model(in0, in1, in2, in3);
        start = 1'b1;
        tick();
        in0 = rw(); in1 = rw(); in2 = rw(); in3 = rw();
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL s1start_done: got %b want 1", done); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_err++; $display("FAIL s1start_extra%0d: got %b want 00", c, {busy, done});
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_s[i] !== exp_s[i]) begin
                    n_err++; $display("FAIL s1start_out%0d: got %h want %h", i, got_s[i], exp_s[i]);
                end
            end
        end
    endtask

    task automatic test_abort();
        in0 = rw(); in1 = rw(); in2 = rw(); in3 = rw();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00 || got_s[0] !== 32'h0) begin
            n_err++; $display("FAIL abort_reset: got busy/done=%b out0=%h want 00/0", {busy, done}, got_s[0]);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (done !== 1'b0) begin n_err++; $display("FAIL abort_no_done%0d: got %b want 0", c, done); end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_s[i] !== 32'h0 || got_u[i] !== 32'h0) begin
                    n_err++; $display("FAIL abort_out%0d: got %h/%h want 0", i, got_s[i], got_u[i]);
                end
            end
        end
        launch(rw(), rw(), rw(), rw());
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL abort_resume_done: got %b want 1", done); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_s[i] !== exp_s[i] || got_u[i] !== exp_u[i]) begin
                n_err++;
                $display("FAIL abort_resume_out%0d: got %h/%h want %h/%h", i, got_s[i], got_u[i], exp_s[i], exp_u[i]);
            end
        end
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_in_s1();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ifft4.md
# ifft4

Four-point radix-2 inverse FFT over packed complex 16+16-bit samples, the inverse-direction companion of the four-point forward FFT in the same datapath. It takes four frequency-domain bins, runs two time-multiplexed butterfly stages with inverse twiddles (W^-k, so -j becomes +j) and scales by 1/N. It produces four time-domain samples with a start/done handshake. It sits after spectral processing to return data to the time domain.

## Interface
- WIDTH, 32, packed complex word width; must be even; H = WIDTH/2 bits per component; real in [WIDTH-1:H], imaginary in [H-1:0], both two's complement
- SCALE, 1, 1 = apply 1/4 scaling (arithmetic shift right by 2); 0 = unscaled, low H bits kept (wraps)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- in0..in3  in  WIDTH each  frequency bins X[0..3]; captured on the accepting edge
- busy  out  1  high in S1 and S2
- done  out  1  one-cycle pulse; out0..out3 valid from this cycle
- out0..out3  out  WIDTH each  time samples x[0..3], natural order, registered

## Operation
- States: IDLE, S1, S2. Encoding is free; IDLE is the reset state.
- IDLE: if start=1 at the edge, register in0..in3 into x0..x3 and go to S1. Otherwise stay. done is cleared unless it is being set this edge.
- S1, per component with sign extension to H+2 bits:
  - e0=x0+x2, e1=x0-x2
  - o0=x1+x3, o1=x1-x3
  - Register e0, e1, o0, o1 and go to S2.
- S2:
  - y0=e0+o0, y2=e0-o0
  - y1=e1+j·o1, y3=e1-j·o1
  - j·(a+jb) = -b + ja
  - Register outputs, set done=1, go to IDLE.
- Output mapping: out0=y0, out1=y1, out2=y2, out3=y3, for each component.
  - SCALE=1: y>>>2 (floor), which fits exactly in H bits with no saturation needed.
  - SCALE=0: y[H-1:0].
- Internal width is H+2 bits per component. No intermediate overflow is possible.
- out0..out3 hold their value until the next S2 completion. They are not cleared by IDLE or by start.
- start while busy=1 is ignored and not queued. The inputs may change freely after the capture edge.
- start=1 in the cycle done=1 is accepted, since the state is IDLE.

## Timing
- Reset: rst=1 asynchronously forces:
  - state to IDLE
  - busy=0, done=0
  - out0..out3=0
  - all internal registers to 0
- Reset mid-operation (S1 or S2) aborts the operation. No done pulse follows, and outputs read 0.
- Release takes effect at the next rising edge; start may be sampled on that first edge.
- Latency: start accepted at edge N.
  - busy=1 after N and after N+1.
  - done=1 and outputs valid after edge N+2; done returns to 0 after N+3 unless re-set.
- Throughput: one transform per 3 cycles with start held high.
- busy=0 whenever done=1.

## Test plan
- Reset: assert rst mid-cycle with no clock edge -> busy, done and out0..3 all 0 immediately. Then start with in0=0x00040000, others 0 -> done after 3rd edge; out0..3 = 0x00010000 each.
- DC bin: in0..3 = {0x0004,0x0000},{0,0},{0,0},{0,0} already covered. Next, in1=0x00040000, others 0 -> out0=0x00010000, out1=0x00000001, out2=0xFFFF0000, out3=0x0000FFFF. This checks the +j twiddle direction.
- Sign and width:
  - all inputs 0x7FFF0000 -> out0=0x7FFF0000, out1..3=0.
  - in0=0xFFFF0000, others 0 -> all outputs 0xFFFF0000 (floor rounding).
- SCALE=0: in0..3 all 0x00010001 -> out0=0x00040004, out1..3=0.
- Handshake: start held high for 10 cycles -> done pulses every 3rd cycle, a single cycle each. A start pulse in S1 -> no extra transform, and outputs are unaffected until the pending done.
- Abort: rst pulsed while in S2 -> no done pulse, outputs 0. A subsequent start completes normally with correct results.
